// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard_if
// Purpose  : Operand-read, pipeline-bypass and issue bundle for fwd_scoreboard.
// Revision : 1.0  initial release
// ============================================================================
interface fwd_scoreboard_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 8
);
    logic [NUM_RD*ADDR_W-1:0] RsAddrIn;
    logic [NUM_RD-1:0]        RsUsedIn;
    logic [NUM_RD*DATA_W-1:0] RsRegFileDataIn;
    logic [NUM_RD*DATA_W-1:0] RsDataOut;
    logic                     IssueValidIn;
    logic [ADDR_W-1:0]        IssueRdIn;
    logic                     IssueRdWriteIn;
    logic                     IssueLongIn;
    logic [DATA_W-1:0]        RdWriteDataEx2MemIn;
    logic [ADDR_W-1:0]        RdAddrEx2MemIn;
    logic                     RdWriteEnableEx2MemIn;
    logic                     IsLoadEx2MemIn;
    logic [DATA_W-1:0]        RdWriteDataMem2WbIn;
    logic [ADDR_W-1:0]        RdAddrMem2WbIn;
    logic                     RdWriteEnableMem2WbIn;
    logic                     LongWbValidIn;
    logic [ADDR_W-1:0]        LongWbRdIn;
    logic [DATA_W-1:0]        LongWbDataIn;
    logic                     TimeoutClrIn;
    logic                     StallOut;
    logic [(2**ADDR_W)-1:0]   BusyVecOut;
    logic [CNT_W-1:0]         StallCntOut;
    logic                     HazardTimeoutOut;

    modport slave (
        input  RsAddrIn, RsUsedIn, RsRegFileDataIn,
        input  IssueValidIn, IssueRdIn, IssueRdWriteIn, IssueLongIn,
        input  RdWriteDataEx2MemIn, RdAddrEx2MemIn, RdWriteEnableEx2MemIn, IsLoadEx2MemIn,
        input  RdWriteDataMem2WbIn, RdAddrMem2WbIn, RdWriteEnableMem2WbIn,
        input  LongWbValidIn, LongWbRdIn, LongWbDataIn, TimeoutClrIn,
        output RsDataOut, StallOut, BusyVecOut, StallCntOut, HazardTimeoutOut
    );

    modport master (
        output RsAddrIn, RsUsedIn, RsRegFileDataIn,
        output IssueValidIn, IssueRdIn, IssueRdWriteIn, IssueLongIn,
        output RdWriteDataEx2MemIn, RdAddrEx2MemIn, RdWriteEnableEx2MemIn, IsLoadEx2MemIn,
        output RdWriteDataMem2WbIn, RdAddrMem2WbIn, RdWriteEnableMem2WbIn,
        output LongWbValidIn, LongWbRdIn, LongWbDataIn, TimeoutClrIn,
        input  RsDataOut, StallOut, BusyVecOut, StallCntOut, HazardTimeoutOut
    );
endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Purpose  : Decode-stage operand forwarding, hazard detection and busy
//            scoreboard for long-latency ops, with stall timeout monitor.
// Revision : 1.0  initial release
// ============================================================================
module fwd_scoreboard #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fwd_scoreboard_if.slave bus
);
    localparam int               NUM_REGS       = 2**ADDR_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic                     timeout_q, timeout_d;

    logic [NUM_REGS-1:0]      long_clr;
    logic [NUM_REGS-1:0]      eff_busy;
    logic [ADDR_W-1:0]        rs_addr [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rs_data;
    logic [NUM_RD-1:0]        load_use;
    logic [NUM_RD-1:0]        raw_busy;
    logic                     waw;
    logic                     stall;
    logic                     accept;

    // A same-cycle long writeback already satisfies a reader of that register.
    always_comb begin
        long_clr = '0;
        if (bus.LongWbValidIn) begin
            long_clr[bus.LongWbRdIn] = 1'b1;
        end
        eff_busy = busy_q & ~long_clr;
    end

    always_comb begin
        rs_data  = '0;
        load_use = '0;
        raw_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rs_addr[i] = bus.RsAddrIn[i*ADDR_W +: ADDR_W];
            if (rs_addr[i] == '0) begin
                rs_data[i*DATA_W +: DATA_W] = '0;
            end else if (bus.RdWriteEnableEx2MemIn && !bus.IsLoadEx2MemIn &&
                         bus.RdAddrEx2MemIn == rs_addr[i]) begin
                rs_data[i*DATA_W +: DATA_W] = bus.RdWriteDataEx2MemIn;
            end else if (bus.RdWriteEnableMem2WbIn && bus.RdAddrMem2WbIn == rs_addr[i]) begin
                rs_data[i*DATA_W +: DATA_W] = bus.RdWriteDataMem2WbIn;
            end else if (bus.LongWbValidIn && bus.LongWbRdIn == rs_addr[i]) begin
                rs_data[i*DATA_W +: DATA_W] = bus.LongWbDataIn;
            end else begin
                rs_data[i*DATA_W +: DATA_W] = bus.RsRegFileDataIn[i*DATA_W +: DATA_W];
            end

            if (bus.IssueValidIn && bus.RsUsedIn[i] && rs_addr[i] != '0) begin
                load_use[i] = bus.IsLoadEx2MemIn && bus.RdWriteEnableEx2MemIn &&
                              (bus.RdAddrEx2MemIn == rs_addr[i]);
                raw_busy[i] = eff_busy[rs_addr[i]];
            end
        end
    end

    assign waw    = bus.IssueValidIn && bus.IssueRdWriteIn && (bus.IssueRdIn != '0) &&
                    eff_busy[bus.IssueRdIn];
    assign stall  = (|load_use) || (|raw_busy) || waw;
    assign accept = bus.IssueValidIn && !stall;

    // Set is applied after clear so a same-register set/clear pair leaves it busy.
    always_comb begin
        busy_d = busy_q & ~long_clr;
        if (accept && bus.IssueLongIn && bus.IssueRdWriteIn && bus.IssueRdIn != '0) begin
            busy_d[bus.IssueRdIn] = 1'b1;
        end

        if (!stall) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q == C_CNT_MAX) begin
            stall_cnt_d = stall_cnt_q;
        end else begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        timeout_d = timeout_q;
        if (bus.TimeoutClrIn) begin
            timeout_d = 1'b0;
        end
        if (stall && stall_cnt_q == C_TIMEOUT_LAST) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.RsDataOut        = rs_data;
    assign bus.StallOut         = stall;
    assign bus.BusyVecOut       = busy_q;
    assign bus.StallCntOut      = stall_cnt_q;
    assign bus.HazardTimeoutOut = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_scoreboard
// Purpose  : Self-checking bench for fwd_scoreboard (vector table + sequences).
// Revision : 1.0  initial release
// ============================================================================
module tb_fwd_scoreboard;
    logic clk;
    logic rst_n;

    fwd_scoreboard_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .CNT_W(8)) bus ();

    fwd_scoreboard #(
        .DATA_W(64), .ADDR_W(5), .NUM_RD(2), .CNT_W(8), .TIMEOUT(200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [8*16-1:0] name;
        logic [4:0]  rs0, rs1;
        logic [1:0]  used;
        logic [63:0] rf0, rf1;
        logic        iv, iw, il;
        logic [4:0]  ird;
        logic [4:0]  exa;
        logic [63:0] exd;
        logic        exwe, exld;
        logic [4:0]  wba;
        logic [63:0] wbd;
        logic        wbwe;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ld;
        logic        clr;
        logic [63:0] e0, e1;
        logic        estall;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic [8*16-1:0] name;
        logic [63:0] d0, d1;
        logic        stall;
        logic [31:0] busy;
        logic [7:0]  cnt;
        logic        tmo;
        logic        chk_data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    vec_t        tbl[$];
    vec_t        v;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_busy;
    int          m_cnt;
    logic        m_tmo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [8*16-1:0] nm, input string fld,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %0s.%0s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Scoreboard side: compare one queued expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk(cur.name, "stall", {63'd0, bus.StallOut}, {63'd0, cur.stall});
            chk(cur.name, "busy", {32'd0, bus.BusyVecOut}, {32'd0, cur.busy});
            chk(cur.name, "cnt", {56'd0, bus.StallCntOut}, {56'd0, cur.cnt});
            chk(cur.name, "timeout", {63'd0, bus.HazardTimeoutOut}, {63'd0, cur.tmo});
            if (cur.chk_data) begin
                chk(cur.name, "data0", bus.RsDataOut[63:0], cur.d0);
                chk(cur.name, "data1", bus.RsDataOut[127:64], cur.d1);
            end
        end
    end

    function automatic vec_t dflt(input logic [8*16-1:0] nm);
        vec_t r;
        r = '{default: '0};
        r.name = nm;
        r.rf0  = 64'h1111;
        r.rf1  = 64'h2222;
        return r;
    endfunction

    // Driver side: apply a vector, queue its expectation, then advance the model.
    task automatic drive(input vec_t d, input logic do_rst);
        exp_t e;
        @(posedge clk);
        #1;
        bus.RsAddrIn              = {d.rs1, d.rs0};
        bus.RsUsedIn              = d.used;
        bus.RsRegFileDataIn       = {d.rf1, d.rf0};
        bus.IssueValidIn          = d.iv;
        bus.IssueRdIn             = d.ird;
        bus.IssueRdWriteIn        = d.iw;
        bus.IssueLongIn           = d.il;
        bus.RdWriteDataEx2MemIn   = d.exd;
        bus.RdAddrEx2MemIn        = d.exa;
        bus.RdWriteEnableEx2MemIn = d.exwe;
        bus.IsLoadEx2MemIn        = d.exld;
        bus.RdWriteDataMem2WbIn   = d.wbd;
        bus.RdAddrMem2WbIn        = d.wba;
        bus.RdWriteEnableMem2WbIn = d.wbwe;
        bus.LongWbValidIn         = d.lv;
        bus.LongWbRdIn            = d.lrd;
        bus.LongWbDataIn          = d.ld;
        bus.TimeoutClrIn          = d.clr;
        if (do_rst) begin
            rst_n  = 1'b0;
            m_busy = '0;
            m_cnt  = 0;
            m_tmo  = 1'b0;
        end else begin
            rst_n = 1'b1;
        end
        e.name     = d.name;
        e.d0       = d.e0;
        e.d1       = d.e1;
        e.stall    = d.estall;
        e.busy     = m_busy;
        e.cnt      = 8'(m_cnt);
        e.tmo      = m_tmo;
        e.chk_data = d.chk_data;
        exp_q.push_back(e);
        if (!do_rst) begin
            if (d.lv) m_busy[d.lrd] = 1'b0;
            if (d.iv && !d.estall && d.il && d.iw && d.ird != 5'd0) m_busy[d.ird] = 1'b1;
            if (d.estall && m_cnt == 199) m_tmo = 1'b1;
            else if (d.clr)              m_tmo = 1'b0;
            m_cnt = d.estall ? ((m_cnt == 255) ? 255 : m_cnt + 1) : 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        m_busy = '0;
        m_cnt  = 0;
        m_tmo  = 1'b0;
        bus.RsAddrIn = '0;              bus.RsUsedIn = '0;
        bus.RsRegFileDataIn = '0;       bus.IssueValidIn = 1'b0;
        bus.IssueRdIn = '0;             bus.IssueRdWriteIn = 1'b0;
        bus.IssueLongIn = 1'b0;         bus.RdWriteDataEx2MemIn = '0;
        bus.RdAddrEx2MemIn = '0;        bus.RdWriteEnableEx2MemIn = 1'b0;
        bus.IsLoadEx2MemIn = 1'b0;      bus.RdWriteDataMem2WbIn = '0;
        bus.RdAddrMem2WbIn = '0;        bus.RdWriteEnableMem2WbIn = 1'b0;
        bus.LongWbValidIn = 1'b0;       bus.LongWbRdIn = '0;
        bus.LongWbDataIn = '0;          bus.TimeoutClrIn = 1'b0;

        // ---------------- forwarding vector table ----------------
        v = dflt("ex_over_wb"); v.iv = 1; v.used = 2'b11; v.rs0 = 5; v.rs1 = 6;
        v.rf1 = 64'h66; v.exa = 5; v.exd = 64'hAA; v.exwe = 1;
        v.wba = 5; v.wbd = 64'hBB; v.wbwe = 1; v.e0 = 64'hAA; v.e1 = 64'h66; v.chk_data = 1;
        tbl.push_back(v);
        v = dflt("x0_zero"); v.iv = 1; v.used = 2'b11; v.rs0 = 4; v.rs1 = 0;
        v.rf0 = 64'h44; v.rf1 = 64'hDEAD; v.exa = 0; v.exd = 64'h55; v.exwe = 1;
        v.e0 = 64'h44; v.e1 = 64'h0; v.chk_data = 1;
        tbl.push_back(v);
        v = dflt("wb_only"); v.iv = 1; v.used = 2'b11; v.rs0 = 8; v.rs1 = 8;
        v.wba = 8; v.wbd = 64'hBB; v.wbwe = 1; v.e0 = 64'hBB; v.e1 = 64'hBB; v.chk_data = 1;
        tbl.push_back(v);
        v = dflt("lwb_only"); v.iv = 1; v.used = 2'b11; v.rs0 = 10; v.rs1 = 11;
        v.rf1 = 64'h77; v.lv = 1; v.lrd = 10; v.ld = 64'hCAFE;
        v.e0 = 64'hCAFE; v.e1 = 64'h77; v.chk_data = 1;
        tbl.push_back(v);
        v = dflt("ex_we0"); v.iv = 1; v.used = 2'b01; v.rs0 = 12; v.rs1 = 1;
        v.exa = 12; v.exd = 64'h1; v.wba = 12; v.wbd = 64'h99; v.wbwe = 1;
        v.e0 = 64'h99; v.e1 = 64'h2222; v.chk_data = 1;
        tbl.push_back(v);
        v = dflt("ld_unused"); v.iv = 1; v.used = 2'b00; v.rs0 = 13; v.rs1 = 13;
        v.exa = 13; v.exd = 64'h1; v.exwe = 1; v.exld = 1;
        v.wba = 13; v.wbd = 64'h31; v.wbwe = 1; v.e0 = 64'h31; v.e1 = 64'h31; v.chk_data = 1;
        tbl.push_back(v);
        v = dflt("ld_no_issue"); v.iv = 0; v.used = 2'b11; v.rs0 = 13; v.rs1 = 2;
        v.exa = 13; v.exd = 64'h1; v.exwe = 1; v.exld = 1;
        v.wba = 13; v.wbd = 64'h31; v.wbwe = 1; v.e0 = 64'h31; v.e1 = 64'h2222; v.chk_data = 1;
        tbl.push_back(v);
        v = dflt("wb_over_lwb"); v.iv = 1; v.used = 2'b01; v.rs0 = 14; v.rs1 = 0;
        v.wba = 14; v.wbd = 64'h42; v.wbwe = 1; v.lv = 1; v.lrd = 14; v.ld = 64'h43;
        v.e0 = 64'h42; v.e1 = 64'h0; v.chk_data = 1;
        tbl.push_back(v);

        drive(dflt("reset"), 1'b1);
        for (int i = 0; i < tbl.size(); i++) drive(tbl[i], 1'b0);

        // ---------------- load-use ----------------
        v = dflt("load_use"); v.iv = 1; v.used = 2'b01; v.rs0 = 7;
        v.exa = 7; v.exd = 64'hEE; v.exwe = 1; v.exld = 1; v.estall = 1;
        drive(v, 1'b0);
        v = dflt("load_resolved"); v.iv = 1; v.used = 2'b01; v.rs0 = 7;
        v.wba = 7; v.wbd = 64'h1234; v.wbwe = 1; v.e0 = 64'h1234; v.e1 = 64'h0; v.chk_data = 1;
        drive(v, 1'b0);

        // ---------------- long op on x9 ----------------
        v = dflt("issue_long9"); v.iv = 1; v.il = 1; v.iw = 1; v.ird = 9;
        drive(v, 1'b0);
        v = dflt("raw_x9"); v.iv = 1; v.used = 2'b01; v.rs0 = 9; v.estall = 1;
        for (int k = 0; k < 3; k++) drive(v, 1'b0);
        v = dflt("lwb_x9"); v.iv = 1; v.used = 2'b01; v.rs0 = 9;
        v.lv = 1; v.lrd = 9; v.ld = 64'hCAFE; v.e0 = 64'hCAFE; v.e1 = 64'h0; v.chk_data = 1;
        drive(v, 1'b0);
        drive(dflt("idle_x9_free"), 1'b0);

        // ---------------- WAW on x3 ----------------
        v = dflt("issue_long3"); v.iv = 1; v.il = 1; v.iw = 1; v.ird = 3;
        drive(v, 1'b0);
        v = dflt("waw_x3"); v.iv = 1; v.iw = 1; v.ird = 3; v.estall = 1;
        drive(v, 1'b0);
        v = dflt("waw_lwb_set"); v.iv = 1; v.il = 1; v.iw = 1; v.ird = 3; v.lv = 1; v.lrd = 3;
        drive(v, 1'b0);
        v = dflt("x3_still_busy"); v.lv = 1; v.lrd = 3;
        drive(v, 1'b0);
        drive(dflt("x3_free"), 1'b0);

        // ---------------- timeout ----------------
        v = dflt("issue_long12"); v.iv = 1; v.il = 1; v.iw = 1; v.ird = 12;
        drive(v, 1'b0);
        v = dflt("raw_x12"); v.iv = 1; v.used = 2'b01; v.rs0 = 12; v.estall = 1;
        for (int k = 0; k < 200; k++) drive(v, 1'b0);
        drive(dflt("stall_end"), 1'b0);
        v = dflt("tmo_clr"); v.clr = 1;
        drive(v, 1'b0);
        drive(dflt("tmo_cleared"), 1'b0);
        v = dflt("raw_x12_again"); v.iv = 1; v.used = 2'b01; v.rs0 = 12; v.estall = 1;
        for (int k = 0; k < 200; k++) begin
            v.clr = (k == 199);
            drive(v, 1'b0);
        end
        v.clr = 0;
        for (int k = 0; k < 2; k++) drive(v, 1'b0);
        v.estall = 0; v.name = "reset_mid_stall";
        drive(v, 1'b1);
        drive(dflt("after_reset"), 1'b0);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the decode-stage forwarding unit.
- Generalises to NUM_RD read ports and configurable widths.
- Adds x0 suppression, a third forwarding source (long-latency writeback), load-use detection, and a 32-entry busy scoreboard for multi-cycle ops (div/mul/miss loads).
- Adds a stall-duration counter with a sticky timeout flag.
- Sits between the register file read and the ID/EX pipeline register; its Stall output freezes IF/ID.

Parameters:
DATA_W, 64, register data width
ADDR_W, 5, register address width (scoreboard depth = 2**ADDR_W)
NUM_RD, 2, number of source read ports
CNT_W, 8, stall counter width
TIMEOUT, 200, stall cycles before HazardTimeout sets (must be < 2**CNT_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
RsAddrIn  in  NUM_RD*ADDR_W  source register addresses; port i is bits [i*ADDR_W +: ADDR_W]
RsUsedIn  in  NUM_RD  port i is actually consumed by the decoding instruction
RsRegFileDataIn  in  NUM_RD*DATA_W  register file read data
RsDataOut  out  NUM_RD*DATA_W  forwarded operand data
IssueValidIn  in  1  decoding instruction is valid
IssueRdIn  in  ADDR_W  its destination register
IssueRdWriteIn  in  1  it writes IssueRdIn
IssueLongIn  in  1  it is a long-latency op (writes back via LongWb)
RdWriteDataEx2MemIn  in  DATA_W  EX/MEM result
RdAddrEx2MemIn  in  ADDR_W  EX/MEM destination
RdWriteEnableEx2MemIn  in  1  EX/MEM writes rd
IsLoadEx2MemIn  in  1  EX/MEM holds a load (data not yet valid)
RdWriteDataMem2WbIn  in  DATA_W  MEM/WB result
RdAddrMem2WbIn  in  ADDR_W  MEM/WB destination
RdWriteEnableMem2WbIn  in  1  MEM/WB writes rd
LongWbValidIn  in  1  long-latency unit writes back this cycle
LongWbRdIn  in  ADDR_W  long writeback destination
LongWbDataIn  in  DATA_W  long writeback data
TimeoutClrIn  in  1  clears HazardTimeout
StallOut  out  1  hold IF/ID, insert bubble into ID/EX
BusyVecOut  out  2**ADDR_W  scoreboard busy bits
StallCntOut  out  CNT_W  consecutive stall cycles
HazardTimeoutOut  out  1  sticky stall-timeout flag

Behaviour:
- Reset (async, rst_n=0): BusyVecOut=0, StallCntOut=0, HazardTimeoutOut=0. StallOut and RsDataOut are combinational from inputs and the reset state.
- Forwarding per port i (combinational). Priority, first match wins:
  - Address 0 → data 0.
  - Ex2Mem match with write enable and not a load → RdWriteDataEx2MemIn.
  - Mem2Wb match with write enable → RdWriteDataMem2WbIn.
  - LongWbValidIn with matching LongWbRdIn → LongWbDataIn.
  - Otherwise → RsRegFileDataIn slice.
- effBusy[r] = BusyVec[r] & ~(LongWbValidIn & LongWbRdIn==r).
- Hazards: each evaluated only when IssueValidIn=1 and the port has RsUsedIn[i]=1; address 0 never hazards.
  - Load-use: Ex2Mem is a load with write enable and RdAddrEx2MemIn matches a used source.
  - RAW-busy: effBusy of a used source is set.
  - WAW: IssueRdWriteIn and effBusy[IssueRdIn].
- StallOut = OR of all hazards.
- Accept = IssueValidIn & ~StallOut.
- Scoreboard update, per clock edge:
  - Clear BusyVec[LongWbRdIn] on LongWbValidIn.
  - Set BusyVec[IssueRdIn] on Accept & IssueLongIn & IssueRdWriteIn & IssueRdIn≠0.
  - Set and clear to the same register in one cycle: set wins.
  - LongWbValidIn to a non-busy register: no effect, no error.
- StallCnt:
  - StallOut=1 → increment, saturating at 2**CNT_W−1.
  - StallOut=0 → 0 next cycle.
- HazardTimeout:
  - Sets the cycle after StallCnt==TIMEOUT−1 while StallOut=1.
  - Held until reset or TimeoutClrIn=1.
  - TimeoutClrIn=1 and a set condition in the same cycle: set wins.
- Reset mid-stall: all state returns to reset values immediately; busy registers are forgotten. Upstream must flush the long unit on reset.

Test Plan:
- Port0=x5, Ex2Mem rd5 data 0xAA (non-load), Mem2Wb rd5 0xBB → RsDataOut port0=0xAA, StallOut=0.
- Port1=x0 with Ex2Mem rd0 write 0x55 → port1 data 0, no stall.
- Ex2Mem load rd7, port0=x7 used → StallOut=1 one cycle. Next cycle Mem2Wb rd7 0x1234 → port0=0x1234, StallOut=0.
- Issue long rd9 accepted → BusyVecOut[9]=1 next cycle. Reader of x9 stalls 3 cycles (StallCntOut 1,2,3). LongWb rd9 0xCAFE in the same cycle as the read → data 0xCAFE, no stall. Busy[9]=0 next cycle.
- Busy[3]=1, issue any instruction writing x3 → StallOut=1 (WAW). Same-cycle LongWb rd3 → stall drops, and a long issue to x3 leaves busy[3]=1.
- Hold a RAW stall for TIMEOUT=200 cycles → HazardTimeoutOut=1 stays after the stall ends. TimeoutClrIn pulse → 0. Drop rst_n mid-stall → all outputs/state 0 asynchronously.
